lemming_tdm_scheduler: RTL and testbench

- Time-multiplexed controller for N lemming agents that share one walk/dig/fall next-state datapath.
- A round-robin slot pointer picks one lemming per enabled cycle, samples that lemming's environment inputs, computes its next state, and writes the state and fall counter back into a per-lemming register file.
- Sits between the level/environment logic and the per-lemming display/status logic. Also supplies per-lemming revive and a live-agent count.

---
 rtl/lemming_tdm_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_lemming_tdm_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lemming_tdm_scheduler.sv
// lemming_tdm_scheduler
//
// Time-multiplexed controller for N lemming agents that share a single
// walk/dig/fall next-state datapath. A round-robin slot pointer selects one
// lemming per run cycle. That lemming's environment inputs are muxed into the
// shared datapath, and the result is written back into a per-lemming
// state/fall-counter register file. The status flags are a plain decode of
// the stored state, so a write at edge k is visible right after edge k.
//
// Parameters:
//   N           number of lemmings (>= 2, any value)
//   FALL_LIMIT  fall-counter value at or above which landing splats
//
// Ports:
//   clk         clock
//   areset      asynchronous, active-high reset
//   run         service the lemming at the current slot and advance the slot
//   bump_left   [N] per-lemming left-wall bump
//   bump_right  [N] per-lemming right-wall bump
//   ground      [N] per-lemming ground present
//   dig         [N] per-lemming dig request
//   revive      [N] per-lemming revive strobe (forces WALK_L, clears counter)
//   walk_left   [N] lemming i in WALK_L
//   walk_right  [N] lemming i in WALK_R
//   aaah        [N] lemming i in FALL_L or FALL_R
//   digging     [N] lemming i in DIG_L or DIG_R
//   splat       [N] lemming i in SPLAT
//   upd_valid   a service occurs this cycle (equals run)
//   upd_idx     current slot index
//   alive_cnt   number of lemmings not in SPLAT
module lemming_tdm_scheduler #(
  parameter int N          = 4,
  parameter int FALL_LIMIT = 20
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     run,
  input  logic [N-1:0]             bump_left,
  input  logic [N-1:0]             bump_right,
  input  logic [N-1:0]             ground,
  input  logic [N-1:0]             dig,
  input  logic [N-1:0]             revive,
  output logic [N-1:0]             walk_left,
  output logic [N-1:0]             walk_right,
  output logic [N-1:0]             aaah,
  output logic [N-1:0]             digging,
  output logic [N-1:0]             splat,
  output logic                     upd_valid,
  output logic [$clog2(N)-1:0]     upd_idx,
  output logic [$clog2(N+1)-1:0]   alive_cnt
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(FALL_LIMIT + 1);
  localparam int AW = $clog2(N + 1);

  localparam logic [IW-1:0] LAST_SLOT = IW'(N - 1);
  localparam logic [CW-1:0] LIMIT     = CW'(FALL_LIMIT);

  // Encoding 7 is never written by the datapath. If it ever appears it
  // decodes to no flag and behaves as WALK_L on its next service.
  typedef enum logic [2:0] {
    ST_WALK_L = 3'd0,
    ST_WALK_R = 3'd1,
    ST_DIG_L  = 3'd2,
    ST_DIG_R  = 3'd3,
    ST_FALL_L = 3'd4,
    ST_FALL_R = 3'd5,
    ST_SPLAT  = 3'd6,
    ST_UNUSED = 3'd7
  } state_t;

  // Per-lemming register file
  state_t          state_reg [N];
  logic [CW-1:0]   cnt_reg   [N];
  logic [IW-1:0]   slot_reg;

  // Shared datapath signals for the lemming at the current slot
  state_t          svc_state;
  logic [CW-1:0]   svc_cnt;
  logic            svc_bl;
  logic            svc_br;
  logic            svc_gnd;
  logic            svc_dig;
  state_t          state_next;
  logic [CW-1:0]   cnt_next;

  // ------------------------------------------------------------------
  // Slot pointer: wraps explicitly at N-1 so non-power-of-2 N works.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      slot_reg <= '0;
    end else if (run) begin
      slot_reg <= (slot_reg == LAST_SLOT) ? '0 : slot_reg + IW'(1);
    end
  end

  // ------------------------------------------------------------------
  // Shared next-state datapath. Counter defaults to 0, which covers every
  // non-falling state including the walk->fall entry.
  // ------------------------------------------------------------------
  always_comb begin
    svc_state  = state_reg[slot_reg];
    svc_cnt    = cnt_reg[slot_reg];
    svc_bl     = bump_left[slot_reg];
    svc_br     = bump_right[slot_reg];
    svc_gnd    = ground[slot_reg];
    svc_dig    = dig[slot_reg];
    state_next = svc_state;
    cnt_next   = '0;

    case (svc_state)
      ST_WALK_R: begin
        if (!svc_gnd)     state_next = ST_FALL_R;
        else if (svc_dig) state_next = ST_DIG_R;
        else if (svc_br)  state_next = ST_WALK_L;
      end
      ST_DIG_L: begin
        if (!svc_gnd) state_next = ST_FALL_L;
      end
      ST_DIG_R: begin
        if (!svc_gnd) state_next = ST_FALL_R;
      end
      ST_FALL_L, ST_FALL_R: begin
        if (!svc_gnd) begin
          // Saturate so a long fall cannot wrap back under the limit
          cnt_next = (svc_cnt >= LIMIT) ? LIMIT : svc_cnt + CW'(1);
        end else if (svc_cnt >= LIMIT) begin
          state_next = ST_SPLAT;
        end else begin
          state_next = (svc_state == ST_FALL_L) ? ST_WALK_L : ST_WALK_R;
        end
      end
      ST_SPLAT: begin
        state_next = ST_SPLAT;
      end
      default: begin
        // ST_WALK_L and the unused encoding share the walk-left rules
        state_next = ST_WALK_L;
        if (!svc_gnd)     state_next = ST_FALL_L;
        else if (svc_dig) state_next = ST_DIG_L;
        else if (svc_bl)  state_next = ST_WALK_R;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Register file write-back. Revive outranks a same-cycle service and is
  // independent of run and of the slot pointer.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N; i++) begin
        state_reg[i] <= ST_WALK_L;
        cnt_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (revive[i]) begin
          state_reg[i] <= ST_WALK_L;
          cnt_reg[i]   <= '0;
        end else if (run && (slot_reg == IW'(i))) begin
          state_reg[i] <= state_next;
          cnt_reg[i]   <= cnt_next;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Flag decode straight from stored state
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_flags
      assign walk_left[gi]  = (state_reg[gi] == ST_WALK_L);
      assign walk_right[gi] = (state_reg[gi] == ST_WALK_R);
      assign aaah[gi]       = (state_reg[gi] == ST_FALL_L) ||
                              (state_reg[gi] == ST_FALL_R);
      assign digging[gi]    = (state_reg[gi] == ST_DIG_L) ||
                              (state_reg[gi] == ST_DIG_R);
      assign splat[gi]      = (state_reg[gi] == ST_SPLAT);
    end
  endgenerate

  // Live-agent count: popcount of ~splat
  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < N; i++) begin
      alive_cnt = alive_cnt + AW'(!splat[i]);
    end
  end

  assign upd_valid = run;
  assign upd_idx   = slot_reg;

endmodule

// File: tb/tb_lemming_tdm_scheduler.sv
// Testbench for lemming_tdm_scheduler (N=4, FALL_LIMIT=20).
// Stimulus pushes the expected post-service picture into a queue; a separate
// monitor pops and compares whenever the DUT flags a service.
module tb_lemming_tdm_scheduler;
  localparam int N = 4;
  localparam int WL = 0, WR = 1, DL = 2, DR = 3, FL = 4, FR = 5, SP = 6;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         run = 1'b0;
  logic [N-1:0] bump_left = '0;
  logic [N-1:0] bump_right = '0;
  logic [N-1:0] ground = '1;
  logic [N-1:0] dig = '0;
  logic [N-1:0] revive = '0;
  logic [N-1:0] walk_left, walk_right, aaah, digging, splat;
  logic         upd_valid;
  logic [1:0]   upd_idx;
  logic [2:0]   alive_cnt;

  always #5 clk = ~clk;

  lemming_tdm_scheduler #(.N(N), .FALL_LIMIT(20)) dut (
    .clk(clk), .areset(areset), .run(run),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground),
    .dig(dig), .revive(revive),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
    .digging(digging), .splat(splat),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .alive_cnt(alive_cnt)
  );

  typedef struct {
    int           idx;
    logic [N-1:0] wl, wr, aa, dg, sp;
    int           alive;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_st[N];
  int   exp_slot;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t snapshot(input int idx);
    exp_t e;
    e.idx = idx;
    e.wl = '0; e.wr = '0; e.aa = '0; e.dg = '0; e.sp = '0;
    e.alive = 0;
    for (int i = 0; i < N; i++) begin
      e.wl[i] = (exp_st[i] == WL);
      e.wr[i] = (exp_st[i] == WR);
      e.aa[i] = (exp_st[i] == FL) || (exp_st[i] == FR);
      e.dg[i] = (exp_st[i] == DL) || (exp_st[i] == DR);
      e.sp[i] = (exp_st[i] == SP);
      if (exp_st[i] != SP) e.alive++;
    end
    return e;
  endfunction

  task automatic compare_flags(input string tag, input exp_t e);
    check({tag, ".walk_left"},  32'(walk_left),  32'(e.wl));
    check({tag, ".walk_right"}, 32'(walk_right), 32'(e.wr));
    check({tag, ".aaah"},       32'(aaah),       32'(e.aa));
    check({tag, ".digging"},    32'(digging),    32'(e.dg));
    check({tag, ".splat"},      32'(splat),      32'(e.sp));
    check({tag, ".alive_cnt"},  32'(alive_cnt),  32'(e.alive));
  endtask

  // Direct check outside of a service (reset, idle, async reset)
  task automatic compare_now(input string tag);
    exp_t e;
    e = snapshot(exp_slot);
    check({tag, ".upd_idx"},   32'(upd_idx),   32'(exp_slot));
    check({tag, ".upd_valid"}, 32'(upd_valid), 32'(run));
    compare_flags(tag, e);
    $display("idle %s: idx=%0d wl=%b wr=%b aaah=%b dig=%b splat=%b alive=%0d",
             tag, upd_idx, walk_left, walk_right, aaah, digging, splat, alive_cnt);
  endtask

  // One service of the lemming at the expected slot. Non-serviced lanes get
  // hostile values; they must be ignored.
  task automatic serve(input bit bl, input bit br, input bit gnd, input bit dg,
                       input int nxt, input logic [N-1:0] rev = '0);
    int s;
    s = exp_slot;
    bump_left = '1; bump_right = '1; ground = '0; dig = '1;
    bump_left[s] = bl; bump_right[s] = br; ground[s] = gnd; dig[s] = dg;
    revive = rev;
    run = 1'b1;
    exp_st[s] = nxt;
    for (int i = 0; i < N; i++) if (rev[i]) exp_st[i] = WL;
    q.push_back(snapshot(s));
    @(posedge clk); #2;
    run = 1'b0;
    revive = '0;
    exp_slot = (s == N - 1) ? 0 : s + 1;
  endtask

  task automatic benign();
    serve(1'b0, 1'b0, 1'b1, 1'b0, exp_st[exp_slot]);
  endtask

  task automatic to_slot(input int t);
    while (exp_slot != t) benign();
  endtask

  // Monitor: capture index mid-cycle, compare the written-back picture just
  // after the servicing edge.
  initial begin
    exp_t e;
    logic [1:0] idx;
    forever begin
      @(negedge clk);
      if (upd_valid === 1'b1) begin
        idx = upd_idx;
        @(posedge clk); #1;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_update: got service at idx %0d, expected none", idx);
        end else begin
          e = q.pop_front();
          check("upd_idx", 32'(idx), 32'(e.idx));
          compare_flags("svc", e);
          $display("svc idx=%0d wl=%b wr=%b aaah=%b dig=%b splat=%b alive=%0d",
                   idx, walk_left, walk_right, aaah, digging, splat, alive_cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    exp_slot = 0;
    for (int i = 0; i < N; i++) exp_st[i] = WL;

    // Reset held with run=0
    repeat (5) begin @(posedge clk); #2; compare_now("reset"); end
    areset = 1'b0;
    @(posedge clk); #2;
    compare_now("post_reset");

    // Round robin with bump_left[2] held
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        serve(i == 2, 1'b0, 1'b1, 1'b0, (i == 2) ? WR : exp_st[i]);

    // run=0 holds slot and state
    repeat (2) begin @(posedge clk); #2; compare_now("hold"); end

    // 20 services without ground, then land safely
    for (int k = 0; k < 20; k++) begin serve(0, 0, 0, 0, FL); to_slot(0); end
    serve(0, 0, 1, 0, WL);
    to_slot(0);

    // 21 services without ground, then splat; splat ignores inputs
    for (int k = 0; k < 21; k++) begin serve(0, 0, 0, 0, FL); to_slot(0); end
    serve(0, 0, 1, 0, SP);
    to_slot(0);
    serve(1, 1, 0, 1, SP);
    to_slot(0);
    serve(0, 1, 1, 1, SP);

    // Slot 1: dig beats bump; lemming 3 exercises the right-hand path
    serve(1, 0, 1, 1, DL); benign(); serve(1, 0, 1, 0, WR); benign();
    serve(1, 1, 0, 0, FL); benign(); serve(0, 1, 1, 1, DR); benign();
    serve(0, 0, 1, 0, WL); serve(0, 1, 1, 0, WL); serve(1, 1, 0, 0, FR); benign();
    benign(); benign(); serve(0, 0, 1, 0, WR);

    // Revive of splatted lemming 0 at its own slot with ground=0
    serve(0, 0, 0, 0, SP, 4'b0001);
    // Revive of non-serviced lemming 3 while slot 1 is serviced
    serve(0, 0, 1, 0, exp_st[1], 4'b1000);
    to_slot(0);

    // Asynchronous reset while lemming 0 is falling
    serve(0, 0, 0, 0, FL);
    benign();
    areset = 1'b1;
    #1;
    exp_slot = 0;
    for (int i = 0; i < N; i++) exp_st[i] = WL;
    compare_now("async_reset");
    @(posedge clk); #2;
    areset = 1'b0;
    for (int i = 0; i < N; i++) benign();

    check("pending", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
